// File: rtl/led_pio_pkg.sv
// Shared register map, STATUS layout and helpers for the LED PIO with blink and PWM.
package led_pio_pkg;
   localparam int unsigned ADDR_W = 3;

   localparam logic [ADDR_W-1:0] ADDR_DATA     = 3'd0;
   localparam logic [ADDR_W-1:0] ADDR_BLINK_EN = 3'd1;
   localparam logic [ADDR_W-1:0] ADDR_OUTSET   = 3'd2;
   localparam logic [ADDR_W-1:0] ADDR_OUTCLEAR = 3'd3;
   localparam logic [ADDR_W-1:0] ADDR_PERIOD   = 3'd4;
   localparam logic [ADDR_W-1:0] ADDR_DUTY     = 3'd5;
   localparam logic [ADDR_W-1:0] ADDR_STATUS   = 3'd6;

   localparam int unsigned STATUS_PHASE_BIT = 0;
   localparam int unsigned STATUS_WIDTH_LSB = 8;
   localparam int unsigned STATUS_WIDTH_W   = 8;

   // STATUS word: blink phase in bit 0, channel count in bits [15:8].
   function automatic logic [31:0] status_word(input logic phase, input int unsigned width);
      logic [31:0] s;
      s = '0;
      s[STATUS_PHASE_BIT] = phase;
      s[STATUS_WIDTH_LSB +: STATUS_WIDTH_W] = STATUS_WIDTH_W'(width);
      return s;
   endfunction
endpackage

// File: rtl/led_prescaler.sv
// Blink prescaler: down counter reloading from period, toggling phase on each expiry.
module led_prescaler
   import led_pio_pkg::*;
#(
   parameter int unsigned PRESCALE_W   = 24,
   parameter int unsigned RESET_PERIOD = 24999999
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [PRESCALE_W-1:0] period,
   input  logic                  load,
   output logic                  phase
);
   logic [PRESCALE_W-1:0] cnt;

   // A load restarts the count without disturbing the phase, even on an expiry cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt   <= PRESCALE_W'(RESET_PERIOD);
         phase <= 1'b0;
      end else if (load) begin
         cnt <= period;
      end else if (cnt == '0) begin
         cnt   <= period;
         phase <= ~phase;
      end else begin
         cnt <= cnt - PRESCALE_W'(1);
      end
   end
endmodule

// File: rtl/led_pio_pwm.sv
// Avalon-MM LED output PIO with atomic set/clear, per-channel blink and global PWM dimming.
module led_pio_pwm
   import led_pio_pkg::*;
#(
   parameter int unsigned WIDTH        = 10,
   parameter int unsigned PRESCALE_W   = 24,
   parameter int unsigned PWM_W        = 8,
   parameter logic [31:0] RESET_VALUE  = 32'd0,
   parameter int unsigned RESET_PERIOD = 24999999
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] address,
   input  logic              chipselect,
   input  logic              write_n,
   input  logic [31:0]       writedata,
   output logic [31:0]       readdata,
   output logic [WIDTH-1:0]  out_port
);
   logic [WIDTH-1:0]      data_out;
   logic [WIDTH-1:0]      blink_en;
   logic [PRESCALE_W-1:0] period_q;
   logic [PWM_W-1:0]      duty;
   logic [PWM_W-1:0]      pwm_cnt;
   logic                  phase;

   logic                  wr_c;
   logic                  period_wr_c;
   logic [WIDTH-1:0]      wd_c;
   logic [PRESCALE_W-1:0] period_src_c;
   logic                  pwm_on_c;
   logic                  unused_wd_c;

   assign wr_c         = chipselect & ~write_n;
   assign period_wr_c  = wr_c & (address == ADDR_PERIOD);
   assign wd_c         = writedata[WIDTH-1:0];
   // Prescaler loads the value being written, not the stale register.
   assign period_src_c = period_wr_c ? writedata[PRESCALE_W-1:0] : period_q;
   assign pwm_on_c     = (duty == '1) | (pwm_cnt < duty);
   // Upper writedata bits beyond each register's width are deliberately dropped.
   assign unused_wd_c  = ^writedata;

   always_ff @(posedge clk) begin
      if (reset) begin
         data_out <= WIDTH'(RESET_VALUE);
         blink_en <= '0;
         period_q <= PRESCALE_W'(RESET_PERIOD);
         duty     <= '1;
      end else if (wr_c) begin
         case (address)
            ADDR_DATA:     data_out <= wd_c;
            ADDR_BLINK_EN: blink_en <= wd_c;
            ADDR_OUTSET:   data_out <= data_out | wd_c;
            ADDR_OUTCLEAR: data_out <= data_out & ~wd_c;
            ADDR_PERIOD:   period_q <= writedata[PRESCALE_W-1:0];
            ADDR_DUTY:     duty     <= writedata[PWM_W-1:0];
            default:       ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) pwm_cnt <= '0;
      else       pwm_cnt <= pwm_cnt + PWM_W'(1);
   end

   led_prescaler #(
      .PRESCALE_W   (PRESCALE_W),
      .RESET_PERIOD (RESET_PERIOD)
   ) u_prescaler (
      .clk    (clk),
      .reset  (reset),
      .period (period_src_c),
      .load   (period_wr_c),
      .phase  (phase)
   );

   // Output stage: one register after data, blink phase and PWM gate.
   always_ff @(posedge clk) begin
      if (reset) out_port <= WIDTH'(RESET_VALUE);
      else       out_port <= data_out & (~blink_en | {WIDTH{phase}}) & {WIDTH{pwm_on_c}};
   end

   always_comb begin
      readdata = '0;
      case (address)
         ADDR_DATA:     readdata = 32'(data_out);
         ADDR_BLINK_EN: readdata = 32'(blink_en);
         ADDR_PERIOD:   readdata = 32'(period_q);
         ADDR_DUTY:     readdata = 32'(duty);
         ADDR_STATUS:   readdata = status_word(phase, WIDTH);
         default:       readdata = '0;
      endcase
   end
endmodule

// File: tb/tb_led_pio_pwm.sv
// Self-checking bench for led_pio_pwm against a time-based behavioural model.
module tb_led_pio_pwm;
   import led_pio_pkg::*;

   localparam int unsigned WIDTH      = 10;
   localparam int unsigned PRESCALE_W = 24;
   localparam int unsigned PWM_W      = 8;
   localparam logic [31:0] RV         = 32'h2A5;
   localparam int unsigned RP         = 40;
   localparam logic [31:0] WMASK      = 32'h3FF;
   localparam logic [31:0] PMASK      = 32'h00FF_FFFF;

   logic             clk = 1'b0;
   logic             reset;
   logic [2:0]       address;
   logic             chipselect;
   logic             write_n;
   logic [31:0]      writedata;
   logic [31:0]      readdata;
   logic [WIDTH-1:0] out_port;

   led_pio_pwm #(
      .WIDTH(WIDTH), .PRESCALE_W(PRESCALE_W), .PWM_W(PWM_W),
      .RESET_VALUE(RV), .RESET_PERIOD(RP)
   ) dut (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(readdata), .out_port(out_port)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Model: register contents plus phase/PWM derived from elapsed edges.
   logic [31:0] m_data, m_blink, m_period, m_duty, exp_out;
   longint      a_e, rst_e;
   logic        a_ph;
   int          tests = 0;
   int          fails = 0;

   function automatic logic phase_at(input longint e);
      longint q;
      q = (e - a_e) / (longint'(m_period) + 1);
      return a_ph ^ q[0];
   endfunction

   function automatic logic [31:0] model_out(input longint e);
      longint pwm;
      logic   on;
      pwm = (e - rst_e) % (longint'(1) << PWM_W);
      on  = (m_duty == 32'hFF) || (pwm < longint'(m_duty));
      return m_data & (~m_blink | {32{phase_at(e)}}) & {32{on}};
   endfunction

   function automatic logic [31:0] model_read(input logic [2:0] a);
      case (a)
         3'd0: return m_data;
         3'd1: return m_blink;
         3'd4: return m_period;
         3'd5: return m_duty;
         3'd6: return {16'h0, 8'(WIDTH), 7'h0, phase_at(longint'(cyc))};
         default: return 32'h0;
      endcase
   endfunction

   // One clock: predict out_port from the pre-edge state, then apply the bus action.
   task automatic tick();
      logic        r, w;
      logic [2:0]  a;
      logic [31:0] d;
      r = reset; w = chipselect && !write_n; a = address; d = writedata;
      exp_out = model_out(longint'(cyc));
      @(posedge clk); #1;
      if (r) begin
         m_data = RV; m_blink = 0; m_period = RP; m_duty = 32'hFF;
         a_e = cyc; rst_e = cyc; a_ph = 1'b0; exp_out = RV;
      end else if (w) begin
         case (a)
            3'd0: m_data  = d & WMASK;
            3'd1: m_blink = d & WMASK;
            3'd2: m_data  = m_data | (d & WMASK);
            3'd3: m_data  = m_data & ~(d & WMASK);
            3'd4: begin
               a_ph = phase_at(longint'(cyc) - 1);
               a_e = cyc; m_period = d & PMASK;
            end
            3'd5: m_duty = d & 32'hFF;
            default: ;
         endcase
      end
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
      tick();
      chipselect = 1'b0; write_n = 1'b1;
   endtask

   task automatic rd(input logic [2:0] a, output logic [31:0] v);
      address = a; #1; v = readdata;
   endtask

   task automatic test_reset();
      logic [31:0] v;
      tests++; if (out_port !== 10'h2A5) begin fails++; $display("FAIL reset_out got %h exp 2a5", out_port); end
      rd(3'd0, v); tests++; if (v !== 32'h2A5) begin fails++; $display("FAIL reset_data got %h exp 2a5", v); end
      rd(3'd5, v); tests++; if (v !== 32'hFF) begin fails++; $display("FAIL reset_duty got %h exp ff", v); end
      rd(3'd6, v); tests++; if (v !== 32'h0A00) begin fails++; $display("FAIL reset_status got %h exp a00", v); end
      rd(3'd4, v); tests++; if (v !== RP) begin fails++; $display("FAIL reset_period got %h exp %h", v, RP); end
      rd(3'd7, v); tests++; if (v !== 32'h0) begin fails++; $display("FAIL reserved_read got %h exp 0", v); end
      address = 3'd6;
      for (int i = 0; i < 45; i++) begin
         tick();
         tests++; if (readdata !== model_read(3'd6)) begin fails++; $display("FAIL reset_phase cyc %0d got %h exp %h", cyc, readdata, model_read(3'd6)); end
         tests++; if (out_port !== exp_out[WIDTH-1:0]) begin fails++; $display("FAIL reset_run_out got %h exp %h", out_port, exp_out[WIDTH-1:0]); end
      end
   endtask

   task automatic test_set_clear();
      logic [31:0] v;
      wr(3'd0, 32'h00F); wr(3'd2, 32'h300); wr(3'd3, 32'h003);
      tests++; if (out_port !== 10'h30F) begin fails++; $display("FAIL setclr_n1 got %h exp 30f", out_port); end
      tick();
      tests++; if (out_port !== 10'h30C) begin fails++; $display("FAIL setclr_n2 got %h exp 30c", out_port); end
      rd(3'd0, v); tests++; if (v !== 32'h30C) begin fails++; $display("FAIL setclr_data got %h exp 30c", v); end
      rd(3'd2, v); tests++; if (v !== 32'h0) begin fails++; $display("FAIL outset_read got %h exp 0", v); end
      rd(3'd3, v); tests++; if (v !== 32'h0) begin fails++; $display("FAIL outclr_read got %h exp 0", v); end
      chipselect = 1'b0; write_n = 1'b0; address = 3'd0; writedata = 32'h0; tick();
      chipselect = 1'b1; write_n = 1'b1; tick();
      chipselect = 1'b0; write_n = 1'b1;
      rd(3'd0, v); tests++; if (v !== 32'h30C) begin fails++; $display("FAIL nowrite_data got %h exp 30c", v); end
   endtask

   task automatic test_blink();
      wr(3'd4, 32'd3); wr(3'd1, 32'h001); wr(3'd0, 32'h003);
      address = 3'd6;
      for (int i = 0; i < 40; i++) begin
         tick();
         tests++; if (out_port !== exp_out[WIDTH-1:0]) begin fails++; $display("FAIL blink_out cyc %0d got %h exp %h", cyc, out_port, exp_out[WIDTH-1:0]); end
         tests++; if (out_port[1] !== 1'b1) begin fails++; $display("FAIL blink_steady got %b exp 1", out_port[1]); end
         tests++; if (readdata !== model_read(3'd6)) begin fails++; $display("FAIL blink_status got %h exp %h", readdata, model_read(3'd6)); end
      end
   endtask

   task automatic test_pwm();
      logic [31:0] duties [3];
      int          want [3];
      int          hi;
      duties[0] = 32'h40; duties[1] = 32'h0; duties[2] = 32'hFF;
      want[0] = 64; want[1] = 0; want[2] = 256;
      wr(3'd1, 32'h0); wr(3'd0, 32'h3FF);
      for (int k = 0; k < 3; k++) begin
         wr(3'd5, duties[k]); tick();
         hi = 0;
         for (int i = 0; i < 256; i++) begin
            tick();
            if (out_port[0]) hi++;
            tests++; if (out_port !== exp_out[WIDTH-1:0]) begin fails++; $display("FAIL pwm_out duty %h got %h exp %h", duties[k], out_port, exp_out[WIDTH-1:0]); end
         end
         tests++; if (hi != want[k]) begin fails++; $display("FAIL pwm_count duty %h got %0d exp %0d", duties[k], hi, want[k]); end
      end
   endtask

   task automatic test_period_reload();
      int   e0, n;
      logic ph0, prev;
      wr(3'd5, 32'hFF); wr(3'd4, 32'd1000);
      repeat ($urandom_range(5, 50)) tick();
      wr(3'd4, 32'd100);
      e0 = cyc; address = 3'd6; #1; ph0 = readdata[0];
      n = 0;
      while (readdata[0] == ph0 && n < 200) begin tick(); n++; end
      tests++; if (cyc - e0 != 101) begin fails++; $display("FAIL reload_gap got %0d exp 101", cyc - e0); end
      wr(3'd4, 32'd0);
      address = 3'd6; #1; prev = readdata[0];
      for (int i = 0; i < 8; i++) begin
         tick();
         tests++; if (readdata[0] !== ~prev) begin fails++; $display("FAIL period0_toggle got %b exp %b", readdata[0], ~prev); end
         prev = readdata[0];
      end
   endtask

   task automatic test_random();
      logic [31:0] v;
      for (int i = 0; i < 600; i++) begin
         chipselect = ($urandom % 4) != 0;
         write_n    = ($urandom % 3) == 0;
         address    = 3'($urandom % 8);
         writedata  = (address == 3'd4) ? ($urandom % 12) : $urandom;
         #1; v = readdata;
         tests++; if (v !== model_read(address)) begin fails++; $display("FAIL rand_read addr %0d got %h exp %h", address, v, model_read(address)); end
         tick();
         tests++; if (out_port !== exp_out[WIDTH-1:0]) begin fails++; $display("FAIL rand_out cyc %0d got %h exp %h", cyc, out_port, exp_out[WIDTH-1:0]); end
      end
      chipselect = 1'b0; write_n = 1'b1;
   endtask

   task automatic test_reset_mid();
      logic [31:0] v;
      wr(3'd1, 32'h155); wr(3'd5, 32'h20); wr(3'd4, 32'd7);
      reset = 1'b1; chipselect = 1'b1; write_n = 1'b0; address = 3'd0; writedata = 32'h3FF;
      tick();
      reset = 1'b0; chipselect = 1'b0; write_n = 1'b1;
      tests++; if (out_port !== 10'h2A5) begin fails++; $display("FAIL rstmid_out got %h exp 2a5", out_port); end
      rd(3'd0, v); tests++; if (v !== 32'h2A5) begin fails++; $display("FAIL rstmid_data got %h exp 2a5", v); end
      rd(3'd1, v); tests++; if (v !== 32'h0) begin fails++; $display("FAIL rstmid_blink got %h exp 0", v); end
      rd(3'd4, v); tests++; if (v !== RP) begin fails++; $display("FAIL rstmid_period got %h exp %h", v, RP); end
      rd(3'd5, v); tests++; if (v !== 32'hFF) begin fails++; $display("FAIL rstmid_duty got %h exp ff", v); end
      wr(3'd5, 32'h10); wr(3'd1, 32'h0F0);
      address = 3'd6;
      for (int i = 0; i < 300; i++) begin
         tick();
         tests++; if (out_port !== exp_out[WIDTH-1:0]) begin fails++; $display("FAIL rstmid_run cyc %0d got %h exp %h", cyc, out_port, exp_out[WIDTH-1:0]); end
         tests++; if (readdata !== model_read(3'd6)) begin fails++; $display("FAIL rstmid_status got %h exp %h", readdata, model_read(3'd6)); end
      end
   endtask

   initial begin
      m_data = 0; m_blink = 0; m_period = 0; m_duty = 0; exp_out = 0;
      a_e = 0; rst_e = 0; a_ph = 1'b0;
      reset = 1'b1; chipselect = 1'b0; write_n = 1'b1; address = 3'd0; writedata = 32'h0;
      tick(); tick();
      reset = 1'b0;
      test_reset();
      test_set_clear();
      test_blink();
      test_pwm();
      test_period_reload();
      test_random();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/led_pio_pwm.md
Name: led_pio_pwm

Overview:
Parametrised Avalon-MM output PIO for board LEDs; next generation of the plain LED output register. Adds atomic set/clear, per-channel blink, and a global PWM brightness control. Sits on the Nios II data master as a zero-wait-state slave and drives the LED pins directly.

Parameters:
WIDTH, 10, number of output channels (1..32)
PRESCALE_W, 24, width of the blink period register/counter (1..32)
PWM_W, 8, width of the PWM counter and DUTY register (1..16)
RESET_VALUE, 0, reset value of DATA (WIDTH bits)
RESET_PERIOD, 24999999, reset value of PERIOD (half-blink = PERIOD+1 clk cycles)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
address  in  3  word register offset
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
writedata  in  32  write data
readdata  out  32  read data, combinational, zero wait states
out_port  out  WIDTH  LED drive, registered

Behaviour:
- One clock; reset is synchronous and active-high. A write occurs only when chipselect=1 and write_n=0. Bits above the register width are ignored on write and read as 0.
- Register map (word offsets):
  - 0 DATA RW: data_out.
  - 1 BLINK_EN RW: per-channel blink enable.
  - 2 OUTSET W: data_out <= data_out | wd; reads 0.
  - 3 OUTCLEAR W: data_out <= data_out & ~wd; reads 0.
  - 4 PERIOD RW: blink reload value.
  - 5 DUTY RW: PWM compare value.
  - 6 STATUS RO: bit0 = blink phase; bits[15:8] = WIDTH.
  - 7 reserved: reads 0.
- readdata is a pure function of address and current register state; read has no side effects.
- Prescaler:
  - cnt counts down each cycle. When cnt==0: cnt<=PERIOD and phase toggles.
  - A write to PERIOD also loads cnt with the new value that same cycle; phase is unchanged.
  - PERIOD=0 toggles phase every cycle.
- PWM:
  - pwm_cnt (PWM_W bits) increments every cycle and wraps from all-ones to 0.
  - pwm_on = (DUTY==all-ones) | (pwm_cnt < DUTY).
  - DUTY=0 gives always off; all-ones gives always on.
- Output, registered with 1-cycle latency from register/counter state:
  - out_port[i] <= data_out[i] & (~blink_en[i] | phase) & pwm_on.
  - A DATA write at cycle N is visible on out_port at N+2: register update at edge N+1, out_port at edge N+2.
- Reset values:
  - data_out=RESET_VALUE, blink_en=0, PERIOD=cnt=RESET_PERIOD.
  - DUTY=all-ones, phase=0, pwm_cnt=0, out_port=RESET_VALUE.
  - Reset mid-operation restores all of these on the next edge, regardless of any concurrent write; reset wins.
- Back-to-back writes on consecutive cycles each take effect; OUTSET/OUTCLEAR operate on the value written the previous cycle.

Decomposition:
- Shared package led_pio_pkg holds the register offset constants (ADDR_DATA..ADDR_STATUS), STATUS field positions, and the address width (3).
- One sub-module, led_prescaler, holds the down counter, reload/load-on-write logic and phase toggle. Ports: clk, reset, period, load, phase.
- PWM counter, register file and output stage stay in the top level.

Test Plan:
- Reset with RESET_VALUE=10'h2A5 -> out_port=10'h2A5, DATA reads 0x2A5, DUTY reads 0xFF, STATUS bit0=0.
- Write DATA=0x00F, OUTSET 0x300, OUTCLEAR 0x003 on consecutive cycles -> DATA reads 0x30C; out_port=0x30C two cycles after the last write; OUTSET/OUTCLEAR read 0; write with chipselect=0 ignored.
- PERIOD=3, BLINK_EN=0x001, DATA=0x003 -> out_port[0] toggles every 4 cycles, out_port[1] stays 1; STATUS bit0 tracks the phase.
- DUTY=0x40 with PWM_W=8 -> out_port high exactly 64 of every 256 cycles. DUTY=0 -> always 0. DUTY=0xFF -> always high.
- Write PERIOD=100 mid-count -> next phase toggle exactly 101 cycles later. PERIOD=0 -> phase toggles every cycle.
- Assert reset during a DATA write of 0x3FF -> after the reset edge, DATA=RESET_VALUE, counters at reset values, and the write is discarded.
